regfile_param_init: RTL and testbench

- Parametrised successor to the 8x8 single-read register file.
- Provides two combinational read ports, one clocked write port, and an optional hard-wired zero register.
- Provides write-to-read bypass for the decode stage.
- Replaces file-based initialisation with a hardware clear sequencer that runs after reset; the pipeline stalls on init_busy until the clear completes.

---
 rtl/regfile_param_init.sv | 128 ++++++++++++
 tb/tb_regfile_param_init.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_init.sv
// regfile_param_init: parametrised register file with two combinational read
// ports, one clocked write port, optional hard-wired zero register, optional
// write-to-read bypass and a post-reset clear sequencer.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   Read_Reg_Num_1 read port 1 address
//   Read_Reg_Num_2 read port 2 address
//   Read_Data_1    read port 1 data (combinational)
//   Read_Data_2    read port 2 data (combinational)
//   RegWrite       write enable
//   Write_Reg_Num  write address
//   Write_Data     write data
//   init_busy      high while the clear sequence runs (registered)
//   wr_drop        one-cycle pulse: a write was discarded (registered)
module regfile_param_init #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       NUM_REGS = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int unsigned       ZERO_REG = 0,
  parameter int unsigned       BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read_Reg_Num_1,
  input  logic [ADDR_W-1:0] Read_Reg_Num_2,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_Reg_Num,
  input  logic [DATA_W-1:0] Write_Data,
  output logic              init_busy,
  output logic              wr_drop
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_init_busy;
  logic                r_wr_drop;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic w_wr_range;
  logic w_wr_zero;
  logic w_wr_drop;
  logic w_wr_commit;
  logic w_wr_fwd;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  assign w_wr_range  = in_range(Write_Reg_Num);
  assign w_wr_zero   = (ZERO_REG != 0) && (Write_Reg_Num == '0);
  assign w_wr_drop   = RegWrite && (r_init_busy || (r_state == StClear) || !w_wr_range);
  // Writes to the zero register are swallowed without flagging a drop.
  assign w_wr_commit = RegWrite && !w_wr_drop && !w_wr_zero;
  // Zero-register reads are masked ahead of the bypass in read_mux.
  assign w_wr_fwd    = (BYPASS != 0) && RegWrite && !w_wr_drop;

  // Control: single-process FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StClear;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
      r_wr_drop   <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_drop;
      case (r_state)
        StClear: begin
          if (r_cnt == LastIdx) begin
            r_state     <= StReady;
            r_init_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        StReady: ;
        default: begin
          r_state     <= StClear;
          r_cnt       <= '0;
          r_init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset: contents survive a reset edge and are rewritten
  // by the clear sequence afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == StClear) begin
        r_regs[r_cnt] <= INIT_VAL;
      end else if (w_wr_commit) begin
        r_regs[Write_Reg_Num] <= Write_Data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (r_init_busy) begin
      d = '0;
    end else if ((ZERO_REG != 0) && (a == '0)) begin
      d = '0;
    end else if (!in_range(a)) begin
      d = '0;
    end else if (w_wr_fwd && (Write_Reg_Num == a)) begin
      d = Write_Data;
    end else begin
      d = r_regs[a];
    end
    return d;
  endfunction

  assign Read_Data_1 = read_mux(Read_Reg_Num_1);
  assign Read_Data_2 = read_mux(Read_Reg_Num_2);
  assign init_busy   = r_init_busy;
  assign wr_drop     = r_wr_drop;

endmodule

// File: tb/tb_regfile_param_init.sv
// Bench for regfile_param_init. Two instances share the stimulus:
//   inst 0: defaults (8 regs, INIT 0x00, no zero reg, bypass on)
//   inst 1: 6 regs, INIT 0x11, zero reg on, bypass off
module tb_regfile_param_init;

  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RegWrite = 1'b0;
  logic [2:0] rr1 = '0, rr2 = '0, wa = '0;
  logic [7:0] wd = '0;

  logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic       busy_a, busy_b, drop_a, drop_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_param_init dut_a (
    .clk           (clk),
    .reset         (reset),
    .Read_Reg_Num_1(rr1),
    .Read_Reg_Num_2(rr2),
    .Read_Data_1   (rd1_a),
    .Read_Data_2   (rd2_a),
    .RegWrite      (RegWrite),
    .Write_Reg_Num (wa),
    .Write_Data    (wd),
    .init_busy     (busy_a),
    .wr_drop       (drop_a)
  );

  regfile_param_init #(
    .DATA_W  (8),
    .ADDR_W  (3),
    .NUM_REGS(6),
    .INIT_VAL(8'h11),
    .ZERO_REG(1),
    .BYPASS  (0)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .Read_Reg_Num_1(rr1),
    .Read_Reg_Num_2(rr2),
    .Read_Data_1   (rd1_b),
    .Read_Data_2   (rd2_b),
    .RegWrite      (RegWrite),
    .Write_Reg_Num (wa),
    .Write_Data    (wd),
    .init_busy     (busy_b),
    .wr_drop       (drop_b)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem  [NI][8];
  int         m_left [NI];   // clear cycles still to run; 0 = ready
  logic       m_drop [NI];
  bit         m_valid = 1'b0;

  function automatic int nregs(int i);   return (i == 0) ? 8 : 6;      endfunction
  function automatic logic [7:0] initv(int i); return (i == 0) ? 8'h00 : 8'h11; endfunction
  function automatic bit zreg(int i);    return i == 1;                endfunction
  function automatic bit byp(int i);     return i == 0;                endfunction

  function automatic logic [7:0] m_read(int i, logic [2:0] a);
    if (m_left[i] > 0) return 8'h00;
    if (zreg(i) && a == 3'd0) return 8'h00;
    if (int'(a) >= nregs(i)) return 8'h00;
    if (byp(i) && RegWrite && wa == a && int'(wa) < nregs(i)) return wd;
    return m_mem[i][a];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_left[i] = nregs(i);
        m_drop[i] = 1'b0;
        m_valid   = 1'b1;
      end else begin
        m_drop[i] = RegWrite && (m_left[i] > 0 || int'(wa) >= nregs(i));
        if (m_left[i] > 0) begin
          m_mem[i][nregs(i) - m_left[i]] = initv(i);
          m_left[i]--;
        end else if (RegWrite && int'(wa) < nregs(i) && !(zreg(i) && wa == 3'd0)) begin
          m_mem[i][wa] = wd;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc rd1 a", 32'(rd1_a), 32'(m_read(0, rr1)));
      check("cyc rd2 a", 32'(rd2_a), 32'(m_read(0, rr2)));
      check("cyc rd1 b", 32'(rd1_b), 32'(m_read(1, rr1)));
      check("cyc rd2 b", 32'(rd2_b), 32'(m_read(1, rr2)));
      check("cyc busy a", 32'(busy_a), 32'(m_left[0] > 0));
      check("cyc busy b", 32'(busy_b), 32'(m_left[1] > 0));
      check("cyc drop a", 32'(drop_a), 32'(m_drop[0]));
      check("cyc drop b", 32'(drop_b), 32'(m_drop[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs the clear after reset release and checks busy length per instance.
  task automatic count_busy(input string tag);
    int ca = 0;
    int cb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      step();
    end
    check({tag, " busy cycles a"}, 32'(ca), 32'd8);
    check({tag, " busy cycles b"}, 32'(cb), 32'd6);
  endtask

  logic [7:0] wtab_a [4] = '{8'h5A, 8'hC3, 8'h01, 8'hFF};
  logic [2:0] wtab_d [4] = '{3'd1, 3'd6, 3'd0, 3'd4};

  initial begin
    // Reset held for two cycles.
    reset = 1'b1;
    step();
    step();
    check("rst busy a", 32'(busy_a), 32'd1);
    check("rst busy b", 32'(busy_b), 32'd1);
    check("rst drop a", 32'(drop_a), 32'd0);
    check("rst rd1 a", 32'(rd1_a), 32'h00);
    check("rst rd2 b", 32'(rd2_b), 32'h00);

    // Release; write to reg2 in the 3rd cycle of the clear.
    reset = 1'b0;
    begin
      int ca = 0;
      int cb = 0;
      for (int i = 0; i < 12; i++) begin
        RegWrite = (i == 2);
        wa = 3'd2;
        wd = 8'hFF;
        if (busy_a) ca++;
        if (busy_b) cb++;
        step();
        if (i == 2) begin
          check("clr drop a", 32'(drop_a), 32'd1);
          check("clr drop b", 32'(drop_b), 32'd1);
        end
        if (i == 3) check("clr drop a end", 32'(drop_a), 32'd0);
      end
      check("init busy cycles a", 32'(ca), 32'd8);
      check("init busy cycles b", 32'(cb), 32'd6);
    end
    RegWrite = 1'b0;

    // Read back every address on both ports.
    for (int a = 0; a < 8; a++) begin
      rr1 = 3'(a);
      rr2 = 3'(7 - a);
      #1;
      check("init rd1 a", 32'(rd1_a), 32'h00);
      check("init rd2 a", 32'(rd2_a), 32'h00);
      check("init rd1 b", 32'(rd1_b), (a >= 1 && a <= 5) ? 32'h11 : 32'h00);
      step();
    end

    // Write then read.
    RegWrite = 1'b1; wa = 3'd3; wd = 8'hA5;
    step();
    check("w3 drop b", 32'(drop_b), 32'd0);
    wa = 3'd7; wd = 8'h3C;
    step();
    check("w7 drop a", 32'(drop_a), 32'd0);
    check("w7 drop b", 32'(drop_b), 32'd1);
    RegWrite = 1'b0; rr1 = 3'd3; rr2 = 3'd7;
    #1;
    check("rd reg3 a", 32'(rd1_a), 32'hA5);
    check("rd reg7 a", 32'(rd2_a), 32'h3C);
    check("rd reg3 b", 32'(rd1_b), 32'hA5);
    check("rd reg7 b", 32'(rd2_b), 32'h00);
    step();

    // Bypass on both ports.
    RegWrite = 1'b1; wa = 3'd5; wd = 8'h77; rr1 = 3'd5; rr2 = 3'd5;
    #1;
    check("byp rd1 a", 32'(rd1_a), 32'h77);
    check("byp rd2 a", 32'(rd2_a), 32'h77);
    check("nobyp rd1 b", 32'(rd1_b), 32'h11);
    check("nobyp rd2 b", 32'(rd2_b), 32'h11);
    step();
    RegWrite = 1'b0;
    #1;
    check("stored reg5 b", 32'(rd1_b), 32'h77);
    step();

    // Zero register.
    RegWrite = 1'b1; wa = 3'd0; wd = 8'h99; rr1 = 3'd0; rr2 = 3'd0;
    #1;
    check("zero byp rd1 b", 32'(rd1_b), 32'h00);
    check("zero byp rd2 b", 32'(rd2_b), 32'h00);
    check("reg0 byp a", 32'(rd1_a), 32'h99);
    step();
    check("zero drop b", 32'(drop_b), 32'd0);
    RegWrite = 1'b0;
    #1;
    check("zero rd b", 32'(rd1_b), 32'h00);
    check("reg0 rd a", 32'(rd1_a), 32'h99);
    step();

    // Reset in READY, then again mid-clear at cnt=4.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("reclr");
    for (int a = 0; a < 8; a++) begin
      rr1 = 3'(a);
      rr2 = 3'(a);
      #1;
      check("reclr rd1 a", 32'(rd1_a), 32'h00);
      check("reclr rd2 b", 32'(rd2_b), (a >= 1 && a <= 5) ? 32'h11 : 32'h00);
      step();
    end

    // A few more writes; read back via storage on port 2 and bypass on port 1.
    for (int k = 0; k < 4; k++) begin
      RegWrite = 1'b1; wa = wtab_d[k]; wd = wtab_a[k];
      rr1 = wtab_d[k]; rr2 = (k > 0) ? wtab_d[k-1] : 3'd2;
      step();
    end
    RegWrite = 1'b0; rr1 = 3'd1; rr2 = 3'd4;
    #1;
    check("tab rd1 a", 32'(rd1_a), 32'h5A);
    check("tab rd2 a", 32'(rd2_a), 32'hFF);
    check("tab rd2 b", 32'(rd2_b), 32'hFF);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
